// File: rtl/cpu_types_pkg.sv
// Shared CPU types: ROB entry/commit records and default ROB sizing.
package cpu_types_pkg;

    localparam int ROB_DEPTH_DEF    = 16;
    localparam int COMMIT_WIDTH_DEF = 2;
    localparam int PREG_W_DEF       = 6;
    localparam int LREG_W_DEF       = 5;

    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic                  has_dest;
        logic [LREG_W_DEF-1:0] lreg;
        logic [PREG_W_DEF-1:0] new_preg;
        logic [PREG_W_DEF-1:0] old_preg;
    } rob_entry_t;

    typedef struct packed {
        logic                  valid;
        logic                  has_dest;
        logic [LREG_W_DEF-1:0] lreg;
        logic [PREG_W_DEF-1:0] new_preg;
        logic [PREG_W_DEF-1:0] free_preg;
    } rob_commit_t;

endpackage

// File: rtl/rob_commit_select.sv
// Combinational in-order retire scan: finds the run of valid+done entries starting at head.
module rob_commit_select #(
    parameter int ROB_DEPTH    = 16,
    parameter int COMMIT_WIDTH = 2,
    parameter int IDX_W        = $clog2(ROB_DEPTH),
    parameter int CNT_W        = $clog2(COMMIT_WIDTH + 1)
) (
    input  logic [IDX_W-1:0]        head,
    input  logic [IDX_W:0]          count,
    input  logic [ROB_DEPTH-1:0]    valid_vec,
    input  logic [ROB_DEPTH-1:0]    done_vec,
    output logic [COMMIT_WIDTH-1:0] retire_mask,
    output logic [CNT_W-1:0]        retire_cnt
);

    logic             run;
    logic [IDX_W-1:0] idx;

    // Once an entry fails, every younger slot is blocked so the mask stays contiguous.
    always_comb begin
        run         = 1'b1;
        idx         = '0;
        retire_mask = '0;
        retire_cnt  = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            idx = head + IDX_W'(k);
            run = run && valid_vec[idx] && done_vec[idx] && ((IDX_W+1)'(k) < count);
            retire_mask[k] = run;
            if (run) retire_cnt = retire_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/rob_multi_commit.sv
// Reorder buffer with multi-bus writeback and up to COMMIT_WIDTH in-order retirements per cycle.
// Optional retired-instruction counter output under ROB_PERF_CNT_EN.
module rob_multi_commit
    import cpu_types_pkg::*;
#(
    parameter int ROB_DEPTH    = ROB_DEPTH_DEF,
    parameter int COMMIT_WIDTH = COMMIT_WIDTH_DEF,
    parameter int CDB_PORTS    = 2,
    parameter int PREG_W       = PREG_W_DEF,
    parameter int LREG_W       = LREG_W_DEF,
    parameter int IDX_W        = $clog2(ROB_DEPTH)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             alloc_valid_i,
    output logic                             alloc_ready_o,
    input  logic                             alloc_has_dest_i,
    input  logic [LREG_W-1:0]                alloc_lreg_i,
    input  logic [PREG_W-1:0]                alloc_new_preg_i,
    input  logic [PREG_W-1:0]                alloc_old_preg_i,
    output logic [IDX_W-1:0]                 alloc_tag_o,
    input  logic [CDB_PORTS-1:0]             wb_valid_i,
    input  logic [CDB_PORTS*IDX_W-1:0]       wb_rob_idx_i,
    input  logic                             flush_i,
    output logic [COMMIT_WIDTH-1:0]          commit_valid_o,
    output logic [COMMIT_WIDTH-1:0]          commit_has_dest_o,
    output logic [COMMIT_WIDTH*LREG_W-1:0]   commit_lreg_o,
    output logic [COMMIT_WIDTH*PREG_W-1:0]   commit_new_preg_o,
    output logic [COMMIT_WIDTH*PREG_W-1:0]   commit_free_preg_o,
    output logic [IDX_W:0]                   count_o,
    output logic                             empty_o
`ifdef ROB_PERF_CNT_EN
    ,
    output logic [31:0]                      commit_count_o
`endif
);

    localparam int CNT_W = $clog2(COMMIT_WIDTH + 1);

    logic [IDX_W:0]          head_q, tail_q, count;
    logic [ROB_DEPTH-1:0]    valid_q, done_q, valid_nxt, done_nxt;
    logic                    has_dest_q [ROB_DEPTH];
    logic [LREG_W-1:0]       lreg_q     [ROB_DEPTH];
    logic [PREG_W-1:0]       new_preg_q [ROB_DEPTH];
    logic [PREG_W-1:0]       old_preg_q [ROB_DEPTH];
    logic [IDX_W-1:0]        slot_idx   [COMMIT_WIDTH];
    logic [IDX_W-1:0]        wb_idx     [CDB_PORTS];
    logic [COMMIT_WIDTH-1:0] retire_mask;
    logic [CNT_W-1:0]        retire_cnt;
    logic                    alloc_fire;

    assign count         = tail_q - head_q;
    assign count_o       = count;
    assign empty_o       = (count == '0);
    assign alloc_ready_o = (count < (IDX_W+1)'(ROB_DEPTH));
    assign alloc_tag_o   = tail_q[IDX_W-1:0];
    assign alloc_fire    = alloc_valid_i && alloc_ready_o;

    for (genvar k = 0; k < COMMIT_WIDTH; k++) begin : g_slot
        assign slot_idx[k] = head_q[IDX_W-1:0] + IDX_W'(k);
    end

    for (genvar p = 0; p < CDB_PORTS; p++) begin : g_wb
        assign wb_idx[p] = wb_rob_idx_i[p*IDX_W +: IDX_W];
    end

    rob_commit_select #(
        .ROB_DEPTH    (ROB_DEPTH),
        .COMMIT_WIDTH (COMMIT_WIDTH),
        .IDX_W        (IDX_W),
        .CNT_W        (CNT_W)
    ) u_select (
        .head        (head_q[IDX_W-1:0]),
        .count       (count),
        .valid_vec   (valid_q),
        .done_vec    (done_q),
        .retire_mask (retire_mask),
        .retire_cnt  (retire_cnt)
    );

    // Writeback is applied before retirement clears so a late duplicate strobe cannot revive a freed slot.
    always_comb begin
        valid_nxt = valid_q;
        done_nxt  = done_q;
        for (int p = 0; p < CDB_PORTS; p++) begin
            if (wb_valid_i[p] && valid_q[wb_idx[p]]) done_nxt[wb_idx[p]] = 1'b1;
        end
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (retire_mask[k]) begin
                valid_nxt[slot_idx[k]] = 1'b0;
                done_nxt[slot_idx[k]]  = 1'b0;
            end
        end
        if (alloc_fire) begin
            valid_nxt[alloc_tag_o] = 1'b1;
            done_nxt[alloc_tag_o]  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q             <= '0;
            tail_q             <= '0;
            valid_q            <= '0;
            done_q             <= '0;
            commit_valid_o     <= '0;
            commit_has_dest_o  <= '0;
            commit_lreg_o      <= '0;
            commit_new_preg_o  <= '0;
            commit_free_preg_o <= '0;
        end else if (flush_i) begin
            head_q             <= '0;
            tail_q             <= '0;
            valid_q            <= '0;
            done_q             <= '0;
            commit_valid_o     <= '0;
            commit_has_dest_o  <= '0;
            commit_lreg_o      <= '0;
            commit_new_preg_o  <= '0;
            commit_free_preg_o <= '0;
        end else begin
            head_q  <= head_q + (IDX_W+1)'(retire_cnt);
            if (alloc_fire) tail_q <= tail_q + 1'b1;
            valid_q <= valid_nxt;
            done_q  <= done_nxt;
            commit_valid_o <= retire_mask;
            for (int k = 0; k < COMMIT_WIDTH; k++) begin
                commit_has_dest_o[k]                   <= retire_mask[k] & has_dest_q[slot_idx[k]];
                commit_lreg_o[k*LREG_W +: LREG_W]      <= retire_mask[k] ? lreg_q[slot_idx[k]]     : '0;
                commit_new_preg_o[k*PREG_W +: PREG_W]  <= retire_mask[k] ? new_preg_q[slot_idx[k]] : '0;
                commit_free_preg_o[k*PREG_W +: PREG_W] <= retire_mask[k] ? old_preg_q[slot_idx[k]] : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            has_dest_q[alloc_tag_o] <= alloc_has_dest_i;
            lreg_q[alloc_tag_o]     <= alloc_lreg_i;
            new_preg_q[alloc_tag_o] <= alloc_new_preg_i;
            old_preg_q[alloc_tag_o] <= alloc_old_preg_i;
        end
    end

`ifdef ROB_PERF_CNT_EN
    logic [31:0] commit_pop;

    always_comb begin
        commit_pop = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) commit_pop = commit_pop + 32'(commit_valid_o[k]);
    end

    // Survives flush: slots shown during a flush cycle have genuinely retired.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) commit_count_o <= '0;
        else     commit_count_o <= commit_count_o + commit_pop;
    end
`endif

    always @(posedge clk) begin
        if (!rst && !flush_i) begin
            for (int p = 0; p < CDB_PORTS; p++) begin
                assert (!wb_valid_i[p] || valid_q[wb_idx[p]]);
            end
        end
    end

endmodule

// File: tb/tb_rob_multi_commit.sv
// Scoreboard bench for rob_multi_commit: expected retirements queued at allocation, popped on commit.
module tb_rob_multi_commit;

    typedef struct {
        logic       hd;
        logic [4:0] lreg;
        logic [5:0] np;
        logic [5:0] op;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        alloc_valid_i, alloc_ready_o, alloc_has_dest_i;
    logic [4:0]  alloc_lreg_i;
    logic [5:0]  alloc_new_preg_i, alloc_old_preg_i;
    logic [3:0]  alloc_tag_o;
    logic [1:0]  wb_valid_i;
    logic [7:0]  wb_rob_idx_i;
    logic        flush_i;
    logic [1:0]  commit_valid_o, commit_has_dest_o;
    logic [9:0]  commit_lreg_o;
    logic [11:0] commit_new_preg_o, commit_free_preg_o;
    logic [4:0]  count_o;
    logic        empty_o;
`ifdef ROB_PERF_CNT_EN
    logic [31:0] commit_count_o;
`endif

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   seq      = 0;
    int   mtail    = 0;

    always #5 clk = ~clk;

    rob_multi_commit dut (
        .clk                (clk),
        .rst                (rst),
        .alloc_valid_i      (alloc_valid_i),
        .alloc_ready_o      (alloc_ready_o),
        .alloc_has_dest_i   (alloc_has_dest_i),
        .alloc_lreg_i       (alloc_lreg_i),
        .alloc_new_preg_i   (alloc_new_preg_i),
        .alloc_old_preg_i   (alloc_old_preg_i),
        .alloc_tag_o        (alloc_tag_o),
        .wb_valid_i         (wb_valid_i),
        .wb_rob_idx_i       (wb_rob_idx_i),
        .flush_i            (flush_i),
        .commit_valid_o     (commit_valid_o),
        .commit_has_dest_o  (commit_has_dest_o),
        .commit_lreg_o      (commit_lreg_o),
        .commit_new_preg_o  (commit_new_preg_o),
        .commit_free_preg_o (commit_free_preg_o),
        .count_o            (count_o),
        .empty_o            (empty_o)
`ifdef ROB_PERF_CNT_EN
        ,
        .commit_count_o     (commit_count_o)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        alloc_valid_i = 1'b0;
        wb_valid_i    = '0;
        flush_i       = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic set_alloc();
        exp_t e;
        e.hd   = (seq % 5) != 0;
        e.lreg = 5'(seq);
        e.np   = 6'(seq + 7);
        e.op   = 6'(seq * 3);
        alloc_valid_i    = 1'b1;
        alloc_has_dest_i = e.hd;
        alloc_lreg_i     = e.lreg;
        alloc_new_preg_i = e.np;
        alloc_old_preg_i = e.op;
        chk("alloc_tag", 64'(alloc_tag_o), 64'(mtail));
        sb.push_back(e);
        seq++;
        mtail = (mtail + 1) % 16;
    endtask

    task automatic set_wb(input int bus, input logic [3:0] idx);
        wb_valid_i[bus]          = 1'b1;
        wb_rob_idx_i[bus*4 +: 4] = idx;
    endtask

    task automatic do_flush();
        flush_i = 1'b1;
        step();
        sb.delete();
        mtail = 0;
        chk("flush_count", 64'(count_o), 0);
        chk("flush_empty", 64'(empty_o), 1);
        chk("flush_no_commit", 64'(commit_valid_o), 0);
        chk("flush_tag", 64'(alloc_tag_o), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && commit_valid_o != 2'b00) begin
            chk("commit_contig", 64'((commit_valid_o & (commit_valid_o + 2'd1)) == 2'b00), 1);
            for (int k = 0; k < 2; k++) begin
                if (commit_valid_o[k]) begin
                    if (sb.size() == 0) begin
                        chk("commit_unexpected", 64'(k), 64'(k + 100));
                    end else begin
                        e = sb.pop_front();
                        chk("commit_has_dest", 64'(commit_has_dest_o[k]), 64'(e.hd));
                        chk("commit_lreg", 64'(commit_lreg_o[k*5 +: 5]), 64'(e.lreg));
                        if (e.hd) begin
                            chk("commit_new_preg", 64'(commit_new_preg_o[k*6 +: 6]), 64'(e.np));
                            chk("commit_free_preg", 64'(commit_free_preg_o[k*6 +: 6]), 64'(e.op));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        int cur;
        rst = 1'b1;
        alloc_valid_i = 1'b0; alloc_has_dest_i = 1'b0;
        alloc_lreg_i = '0; alloc_new_preg_i = '0; alloc_old_preg_i = '0;
        wb_valid_i = '0; wb_rob_idx_i = '0; flush_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", 64'(count_o), 0);
        chk("rst_empty", 64'(empty_o), 1);
        chk("rst_ready", 64'(alloc_ready_o), 1);
        chk("rst_commit", 64'(commit_valid_o), 0);
        chk("rst_tag", 64'(alloc_tag_o), 0);
        rst = 1'b0;

        // Mid-stream async reset with five live entries
        for (int i = 0; i < 5; i++) begin set_alloc(); step(); end
        chk("live_count", 64'(count_o), 5);
        chk("live_empty", 64'(empty_o), 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_count", 64'(count_o), 0);
        chk("arst_empty", 64'(empty_o), 1);
        chk("arst_ready", 64'(alloc_ready_o), 1);
        chk("arst_commit", 64'(commit_valid_o), 0);
        sb.delete();
        mtail = 0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Out-of-order completion blocks retirement until the head is done
        for (int i = 0; i < 3; i++) begin set_alloc(); step(); end
        set_wb(0, 4'd1); step();
        step();
        chk("no_early_commit", 64'(commit_valid_o), 0);
        chk("three_live", 64'(count_o), 3);
        set_wb(1, 4'd0); step();
        chk("commit_latency", 64'(commit_valid_o), 0);
        step();
        chk("two_wide", 64'(commit_valid_o), 64'h3);
        chk("count_after_two", 64'(count_o), 1);
        step();
        chk("tag2_waits", 64'(commit_valid_o), 0);
        set_wb(0, 4'd2); step();
        step();
        chk("tag2_commit", 64'(commit_valid_o), 64'h1);
        step();
        chk("sb_drained_t2", 64'(sb.size()), 0);

        // Full buffer
        do_flush();
        for (int i = 0; i < 16; i++) begin
            chk("ready_filling", 64'(alloc_ready_o), 1);
            set_alloc();
            step();
        end
        chk("full_ready", 64'(alloc_ready_o), 0);
        chk("full_count", 64'(count_o), 16);
        alloc_valid_i = 1'b1;
        step();
        chk("full_ignore_count", 64'(count_o), 16);
        chk("full_ignore_tag", 64'(alloc_tag_o), 0);
        set_wb(0, 4'd0); step();
        step();
        chk("full_one_retire", 64'(commit_valid_o), 64'h1);
        chk("full_count_15", 64'(count_o), 15);
        chk("full_ready_back", 64'(alloc_ready_o), 1);
        for (int i = 1; i < 16; i += 2) begin
            set_wb(0, 4'(i));
            if (i + 1 < 16) set_wb(1, 4'(i + 1));
            step();
        end
        idle(4);
        chk("full_drain_count", 64'(count_o), 0);
        chk("sb_drained_t3", 64'(sb.size()), 0);

        // Streaming with wrap-around, completion one cycle behind allocation
        prev = -1;
        for (int i = 0; i <= 40; i++) begin
            cur = -1;
            if (i < 40) begin
                chk("stream_ready", 64'(alloc_ready_o), 1);
                cur = mtail;
                set_alloc();
            end
            if (prev >= 0) set_wb(i % 2, 4'(prev));
            prev = cur;
            step();
        end
        idle(4);
        chk("stream_count", 64'(count_o), 0);
        chk("stream_empty", 64'(empty_o), 1);
        chk("sb_drained_t4", 64'(sb.size()), 0);

        // Flush beats writeback and allocation in the same cycle
        do_flush();
        for (int i = 0; i < 5; i++) begin set_alloc(); step(); end
        set_wb(0, 4'd3);
        set_wb(1, 4'd4);
        set_alloc();
        flush_i = 1'b1;
        step();
        sb.delete();
        mtail = 0;
        chk("mix_flush_count", 64'(count_o), 0);
        chk("mix_flush_commit", 64'(commit_valid_o), 0);
        chk("mix_flush_empty", 64'(empty_o), 1);
        set_alloc(); step();
        chk("post_flush_commit", 64'(commit_valid_o), 0);
        set_wb(0, 4'd0); step();
        step();
        chk("post_flush_retire", 64'(commit_valid_o), 64'h1);
        idle(2);

        // Ten retirements mixing widths
        do_flush();
        for (int i = 0; i < 10; i++) begin set_alloc(); step(); end
        set_wb(0, 4'd1); step();
        set_wb(0, 4'd0); step();
        set_wb(0, 4'd2); set_wb(1, 4'd3); step();
        for (int t = 4; t < 10; t++) begin set_wb(t % 2, 4'(t)); step(); end
        idle(4);
        chk("perf_drain_count", 64'(count_o), 0);
        chk("sb_drained_t6", 64'(sb.size()), 0);
`ifdef ROB_PERF_CNT_EN
        chk("perf_count", 64'(commit_count_o), 70);
        flush_i = 1'b1;
        step();
        idle(2);
        chk("perf_hold_flush", 64'(commit_count_o), 70);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
